// File: rtl/chi_inv_seq.sv
// rtl/chi_inv_seq.sv - sequential chi row inverse by counter search; CHI_INV_CONST_TIME_EN selects fixed-latency sweep
module chi_inv_seq #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t       state;
    logic [W-1:0] y_reg;
    logic [W-1:0] cnt;
    logic [W-1:0] res_reg;
    logic [W-1:0] chi_cnt;
    logic         match;
    logic         cnt_last;

    // Forward chi of the current candidate, indices wrap around the row.
    for (genvar i = 0; i < W; i++) begin : g_chi
        assign chi_cnt[i] = cnt[i] ^ (~cnt[(i + 1) % W] & cnt[(i + 2) % W]);
    end

    assign match    = (chi_cnt == y_reg);
    assign cnt_last = (cnt == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            y_reg     <= '0;
            cnt       <= '0;
            res_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        y_reg    <= in_data;
                        cnt      <= '0;
                        res_reg  <= '0;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end

                SEARCH: begin
`ifdef CHI_INV_CONST_TIME_EN
                    // Sweep the whole candidate space regardless of where the match lies.
                    if (match) begin
                        res_reg <= cnt;
                    end
                    if (cnt_last) begin
                        out_valid <= 1'b1;
                        out_data  <= match ? cnt : res_reg;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
                    end
`else
                    if (match) begin
                        res_reg   <= cnt;
                        out_data  <= cnt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cnt_last) begin
                        // Only reachable for an even W where chi is not a bijection.
                        res_reg   <= '0;
                        out_data  <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
                    end
`endif
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/chi_inv_seq.md
Name: chi_inv_seq

Overview:
- Sequential inverse of the W-bit chi row mapping b_i = a_i ^ (~a_{(i+1) mod W} & a_{(i+2) mod W}).
- Recovers the preimage a from a chi output b by counter-driven candidate search against a combinational forward chi.
- Sits at the output end of the chi evaluation harness and converts DUT output rows back to input rows for round-trip checking.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- W, 5, row width in bits; must be odd so chi is a bijection (values 3..7 supported).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a chi output row to invert.
- in_ready  output  1  block can accept a row.
- in_data  input  W  chi output row b.
- out_valid  output  1  out_data holds the preimage.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  W  preimage a with chi(a) == b.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0.
  - Internal candidate counter cnt and latched target y_reg = 0.
- Internal signals:
  - y_reg, cnt and res_reg are each W bits.
  - A combinational chi(cnt) is compared against y_reg (match signal).
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: y_reg <= in_data; cnt <= 0; go to SEARCH.
  - Otherwise hold.
- State SEARCH (in_ready = 0, out_valid = 0):
  - If match: res_reg <= cnt; go to DONE.
  - Else: cnt <= cnt + 1.
  - cnt never passes 2^W-1, because a bijective chi guarantees a match by then.
  - If no match at cnt = 2^W-1 (illegal W only): go to DONE with res_reg = 0.
- State DONE:
  - out_valid = 1; out_data = res_reg; in_ready = 0.
  - On out_ready: go to IDLE.
  - out_data and out_valid stay stable while out_ready = 0 (no drop, no change).
- Latency (default build):
  - out_valid rises exactly k+1 cycles after the accepting edge, where k = chi^-1(b).
  - The minimum (b = 0) is 1 cycle; the maximum is 2^W cycles.
- Throughput: the earliest next acceptance is the cycle after the out_valid & out_ready edge. No bypass of IDLE.
- out_data is 0 whenever out_valid = 0; it is driven from res_reg only in DONE.
- in_valid in SEARCH or DONE is ignored and not queued; upstream holds it until in_ready.
- Asynchronous reset mid-SEARCH or mid-DONE:
  - Aborts the operation immediately and returns to the reset values.
  - The pending result is discarded.
- Arithmetic: cnt increments modulo 2^W. All chi indices are taken modulo W.

Optional Feature:
- Macro: CHI_INV_CONST_TIME_EN.
- Defined:
  - SEARCH always sweeps cnt = 0 .. 2^W-1.
  - On a match, res_reg <= cnt and the search continues.
  - Go to DONE after evaluating cnt = 2^W-1.
  - out_valid rises exactly 2^W cycles after the accepting edge, independent of data, for leakage/timing evaluation.
  - The comparator still evaluates every cycle.
- Not defined: early exit on first match (data-dependent latency, as above).
- Handshake, reset and output-stability rules are identical in both builds.

Test Plan:
- Reset, then in_data = 0x00 -> accepted; default build: out_valid 1 cycle later, out_data = 0x00; const-time build: 32 cycles later, out_data = 0x00.
- in_data = 0x09 -> out_data = 0x01 after 2 cycles (chi(1) = 9); in_data = 0x12 -> out_data = 0x02 after 3 cycles (chi(2) = 18).
- in_data = 0x1F -> out_data = 0x1F after 32 cycles (worst case); same 32 in const-time build.
- Exhaustive sweep over all 32 values of a: drive chi(a) -> out_data == a every time; in_ready = 0 throughout SEARCH/DONE.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid = 1 and out_data stable; in_valid pulses ignored; in_ready rises the cycle after out_ready.
- Assert rst_n low mid-SEARCH with in_data = 0x1F -> out_valid = 0, out_data = 0, in_ready = 1 immediately; a new request 0x09 completes with 0x01.
